multicycle_controller: RTL and testbench

Multi-cycle sequencing FSM for the 32-bit MIPS core. It decodes the 6-bit opcode held in the instruction register and drives the shared-datapath control lines cycle by cycle through fetch, decode, execute, memory and write-back. It replaces single-cycle combinational decode with one ALU, one unified memory port and one register-file write port. It also stalls on memory wait-states, flags illegal opcodes and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 128 ++++++++++++
 tb/tb_multicycle_controller.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode and control-field encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_S  = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    ILLEGAL  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller-to-datapath control bus with controller and datapath views
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic        branch_ne;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        illegal_op;
  logic        retire;
  logic [31:0] instret;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d,
           mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, illegal_op, retire, instret
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d,
           mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, illegal_op, retire, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS sequencing FSM with wait-state stalls and retire counter
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  multicycle_controller_if.master bus
);

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] instret_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET_S:  state_d = FETCH;
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE:       state_d = EXEC_R;
          OP_ADDI:        state_d = EXEC_I;
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default:        state_d = ILLEGAL;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.mem_ready) state_d = WB_MEM;
      MEM_WR:   if (bus.mem_ready) state_d = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, ILLEGAL: state_d = FETCH;
      default:  state_d = RESET_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_S;
      op_q      <= OP_RTYPE;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
      if (bus.retire) instret_q <= instret_q + 32'd1;
    end
  end

  // Moore decode; only FETCH's IR/PC loads and MEM_WR's retire look at mem_ready.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_src        = PC_SRC_ALU;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.alu_op        = ALU_ADD;
    bus.illegal_op    = 1'b0;
    bus.retire        = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE:   bus.alu_src_b = SRCB_IMM_SH2;
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.retire    = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      WB_I: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        bus.retire    = bus.mem_ready;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PC_SRC_ALUOUT;
        bus.branch_ne     = (op_q == OP_BNE);
        bus.retire        = 1'b1;
      end
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_JUMP;
        bus.retire   = 1'b1;
      end
      ILLEGAL:  bus.illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // {pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d, mem_read, mem_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, retire}
  localparam logic [18:0] E_ZERO  = 19'b0_0_0_00_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [18:0] E_FETCH = 19'b1_0_0_00_1_0_1_0_0_0_0_0_01_00_0_0;
  localparam logic [18:0] E_FWAIT = 19'b0_0_0_00_0_0_1_0_0_0_0_0_01_00_0_0;
  localparam logic [18:0] E_DEC   = 19'b0_0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
  localparam logic [18:0] E_EXR   = 19'b0_0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [18:0] E_WBR   = 19'b0_0_0_00_0_0_0_0_0_1_1_0_00_00_0_1;
  localparam logic [18:0] E_EXI   = 19'b0_0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [18:0] E_WBI   = 19'b0_0_0_00_0_0_0_0_0_0_1_0_00_00_0_1;
  localparam logic [18:0] E_MRD   = 19'b0_0_0_00_0_1_1_0_0_0_0_0_00_00_0_0;
  localparam logic [18:0] E_WBM   = 19'b0_0_0_00_0_0_0_0_1_0_1_0_00_00_0_1;
  localparam logic [18:0] E_MWRW  = 19'b0_0_0_00_0_1_0_1_0_0_0_0_00_00_0_0;
  localparam logic [18:0] E_MWR   = 19'b0_0_0_00_0_1_0_1_0_0_0_0_00_00_0_1;
  localparam logic [18:0] E_BNE   = 19'b0_1_1_01_0_0_0_0_0_0_0_1_00_01_0_1;
  localparam logic [18:0] E_BEQ   = 19'b0_1_0_01_0_0_0_0_0_0_0_1_00_01_0_1;
  localparam logic [18:0] E_JUMP  = 19'b1_0_0_10_0_0_0_0_0_0_0_0_00_00_0_1;
  localparam logic [18:0] E_ILL   = 19'b0_0_0_00_0_0_0_0_0_0_0_0_00_00_1_0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        rdy;
    logic [18:0] exp;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [18:0] ctrl_word();
    return {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_src, bus.ir_write,
            bus.i_or_d, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal_op,
            bus.retire};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [5:0] op, input logic rdy,
                     input logic [18:0] exp, input logic [31:0] inst);
    vec_t v;
    v.name = n; v.op = op; v.rdy = rdy; v.exp = exp; v.inst = inst;
    vecs.push_back(v);
  endtask

  task automatic step(input string n, input logic [5:0] op, input logic rdy,
                      input logic [18:0] exp, input logic [31:0] inst);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    #1;
    check({n, ".ctrl"}, {13'd0, ctrl_word()}, {13'd0, exp});
    check({n, ".instret"}, bus.instret, inst);
    @(negedge clk);
  endtask

  initial begin
    add("reset_s",  6'b111111, 1'b1, E_ZERO,  32'd0);
    add("r.fetch",  6'b111111, 1'b1, E_FETCH, 32'd0);
    add("r.decode", 6'b000000, 1'b0, E_DEC,   32'd0);
    add("r.exec",   6'b100011, 1'b1, E_EXR,   32'd0);
    add("r.wb",     6'b100011, 1'b0, E_WBR,   32'd0);
    add("lw.fetch", 6'b000000, 1'b1, E_FETCH, 32'd1);
    add("lw.dec",   6'b100011, 1'b1, E_DEC,   32'd1);
    add("lw.addr",  6'b101011, 1'b0, E_EXI,   32'd1);
    add("lw.rd0",   6'b101011, 1'b0, E_MRD,   32'd1);
    add("lw.rd1",   6'b101011, 1'b0, E_MRD,   32'd1);
    add("lw.rd2",   6'b101011, 1'b1, E_MRD,   32'd1);
    add("lw.wb",    6'b101011, 1'b0, E_WBM,   32'd1);
    add("sw.fwait", 6'b000000, 1'b0, E_FWAIT, 32'd2);
    add("sw.fetch", 6'b000000, 1'b1, E_FETCH, 32'd2);
    add("sw.dec",   6'b101011, 1'b1, E_DEC,   32'd2);
    add("sw.addr",  6'b100011, 1'b1, E_EXI,   32'd2);
    add("sw.wr0",   6'b100011, 1'b0, E_MWRW,  32'd2);
    add("sw.wr1",   6'b100011, 1'b1, E_MWR,   32'd2);
    add("ai.fetch", 6'b000000, 1'b1, E_FETCH, 32'd3);
    add("ai.dec",   6'b001000, 1'b1, E_DEC,   32'd3);
    add("ai.exec",  6'b001000, 1'b1, E_EXI,   32'd3);
    add("ai.wb",    6'b001000, 1'b1, E_WBI,   32'd3);
    add("bne.fet",  6'b000000, 1'b1, E_FETCH, 32'd4);
    add("bne.dec",  6'b000101, 1'b0, E_DEC,   32'd4);
    add("bne.br",   6'b000100, 1'b0, E_BNE,   32'd4);
    add("beq.fet",  6'b000000, 1'b1, E_FETCH, 32'd5);
    add("beq.dec",  6'b000100, 1'b1, E_DEC,   32'd5);
    add("beq.br",   6'b000101, 1'b1, E_BEQ,   32'd5);
    add("ill.fet",  6'b000000, 1'b1, E_FETCH, 32'd6);
    add("ill.dec",  6'b111111, 1'b1, E_DEC,   32'd6);
    add("ill.st",   6'b111111, 1'b1, E_ILL,   32'd6);
    add("post.fet", 6'b000000, 1'b1, E_FETCH, 32'd6);

    rst_n = 1'b0;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("in_reset.ctrl", {13'd0, ctrl_word()}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].op, vecs[i].rdy, vecs[i].exp, vecs[i].inst);

    // lw stalled in MEM_RD, then reset asynchronously between clock edges
    step("rst.dec",  6'b100011, 1'b1, E_DEC, 32'd6);
    step("rst.addr", 6'b000000, 1'b0, E_EXI, 32'd6);
    bus.mem_ready = 1'b0;
    #1;
    check("rst.mrd.ctrl", {13'd0, ctrl_word()}, {13'd0, E_MRD});
    #2 rst_n = 1'b0;
    #1;
    check("rst.low.ctrl", {13'd0, ctrl_word()}, 32'd0);
    check("rst.low.instret", bus.instret, 32'd0);
    @(negedge clk);
    #1;
    check("rst.hold.ctrl", {13'd0, ctrl_word()}, 32'd0);
    rst_n = 1'b1;
    step("rst.reset_s", 6'b000000, 1'b1, E_ZERO, 32'd0);
    step("rst.fetch",   6'b000000, 1'b1, E_FETCH, 32'd0);

    // counter wrap on a jump
    bus.opcode = 6'b000010;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    step("j.dec",   6'b000010, 1'b1, E_DEC,   32'hFFFF_FFFF);
    step("j.jump",  6'b000010, 1'b0, E_JUMP,  32'hFFFF_FFFF);
    step("j.fetch", 6'b000000, 1'b1, E_FETCH, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
